datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
- Multi-cycle control sequencer for the 8-bit datapath. Drives every datapath control strobe: register writes, ALU, RAM, register-to-bus and immediate bus override.
- Accepts one 16-bit instruction per valid/ready handshake, then expands it into 1-3 control steps.
- Sits between the instruction source (fetch unit or testbench) and the datapath. Replaces hand-driven control sequences.

Parameters:
- IMM_W, 8, immediate/bus width; must equal datapath bus width.

Ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_instr  in  16  instruction word [15:13] opcode, [12] rd, [11] ra, [10:9] aluOp, [8] shiftLeft, [7:0] imm
- i_instrValid  in  1  i_instr valid
- o_instrReady  out  1  sequencer can accept an instruction
- o_busOverride  out  IMM_W  immediate driven onto the datapath bus
- o_busOverrideEn  out  1  o_busOverride drives the bus; when 0 the datapath sees Z
- o_ctrlRegWr0 / o_ctrlRegWr1  out  1 each  write bus into r0 / r1
- o_ctrlRegBusSel  out  1  register placed on bus (0=r0, 1=r1)
- o_ctrlRegBusEn  out  1  register file drives bus
- o_ctrlAluBWr  out  1  latch bus into ALU B
- o_ctrlAluOp  out  2  ALU operation
- o_ctrlAluShiftLeft  out  1  shift direction
- o_ctrlAluOE  out  1  ALU result onto bus
- o_ctrlRamAddressEn  out  1  latch bus into RAM address
- o_ctrlRamWriteEn  out  1  write bus into RAM
- o_ctrlRamReadDataSelect  out  1  RAM read path select
- o_ctrlRamOE  out  1  RAM data onto bus
- o_done  out  1  1-cycle pulse on final step of an instruction
- o_illegal  out  1  1-cycle pulse when an undefined opcode is accepted
- o_halted  out  1  high in HALT state

Behaviour:
- States: IDLE, EXEC, HALT. 2-bit step counter; instruction register latched on accept.
- Reset: state IDLE, step 0, instruction register 0, all outputs 0. o_instrReady is 0 during the reset cycle and rises the cycle after reset deasserts.
- A reset asserted mid-EXEC aborts the instruction; outputs are 0 on the next edge and no o_done is produced.
- Handshake:
  - o_instrReady=1 only in IDLE.
  - Accept on valid&ready at a clock edge, then EXEC step 0 on the next cycle.
  - i_instr is ignored while not ready.
- Control outputs are decoded from registered state/step/instruction only; there is no combinational path from inputs.
- Opcode steps (listed controls are 1, all others 0). o_done is high on the last step, then the block returns to IDLE.
  - 000 NOP: step0 no controls.
  - 001 LDI: step0 busOverride=imm, busOverrideEn, RegWr[rd].
  - 010 ALUI:
    - step0 busOverride=imm, busOverrideEn, AluBWr.
    - step1 AluOp/ShiftLeft from instr.
    - step2 AluOp/ShiftLeft held, AluOE, RegWr[rd].
  - 011 ST [ra]=rd:
    - step0 RegBusSel=ra, RegBusEn, RamAddressEn.
    - step1 RegBusSel=rd, RegBusEn, RamWriteEn.
  - 100 LD rd=[ra]:
    - step0 RegBusSel=ra, RegBusEn, RamAddressEn.
    - step1 RamReadDataSelect, RamOE, RegWr[rd].
  - 111 HALT: step0 o_done, then HALT. HALT holds o_halted=1 and o_instrReady=0 until reset.
  - 101, 110: treated as NOP, with o_illegal pulsed in step0 alongside o_done.
- Invariant: never more than one bus driver per cycle (busOverrideEn, RegBusEn, AluOE, RamOE are mutually exclusive); assert in simulation.
- Latency from accept to o_done: 1/1/3/2/2 cycles for NOP/LDI/ALUI/ST/LD. Next accept possible the cycle after o_done.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined: adds output o_retiredCount (16 bits), incremented on each o_done, wraps 0xFFFF->0, reset to 0. o_illegal instructions count; aborted instructions do not.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package datapath_seq_pkg:
  - opcode enum
  - state enum
  - instruction field bit positions
  - packed struct ctrl_t bundling all datapath control outputs
- Sub-module datapath_seq_decode: combinational (opcode, step, fields) -> ctrl_t, last_step, illegal. The FSM/counter stays in the top.

Test Plan:
- Reset 10 cycles with i_instrValid=1: all outputs 0, no accept; o_instrReady=1 the cycle after reset drops.
- LDI r0,0x2A (0x202A): next cycle busOverride=0x2A, busOverrideEn=1, RegWr0=1, o_done=1; ready again the following cycle.
- ALUI r1,aluOp=11,shr,imm 0x01 (0x5601): 3 EXEC cycles exactly as specified; RegWr1 and AluOE only in step2, AluOp=11 in steps 1-2.
- ST [r0]=r1 (0x7000) then LD r0=[r0] (0x8000) back-to-back with valid held high: step patterns match the spec; bus-driver exclusivity assertion never fires.
- Opcode 101 (0xA000) -> o_illegal and o_done in the same cycle, no other controls. Then HALT (0xE000) -> o_halted=1 and ready=0 for 20 cycles; reset -> IDLE.
- Reset asserted in ALUI step1 -> outputs 0 next edge, no o_done; with SEQ_PERF_CNT_EN, o_retiredCount=0, and it counts 3 after three NOPs.

Source files
------------

// File: rtl/datapath_seq_pkg.sv
// datapath_seq_pkg
// Shared definitions for the datapath sequencer:
// - opcode and FSM state encodings;
// - bit positions of the instruction word fields;
// - the ctrl_t bundle that carries every datapath control strobe;
// - a helper that counts how many bus drivers a ctrl_t enables.
package datapath_seq_pkg;

    localparam int SEQ_IMM_W = 8;
    localparam int INSTR_W   = 16;

    // Instruction word layout
    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 13;
    localparam int RD_BIT   = 12;
    localparam int RA_BIT   = 11;
    localparam int ALUOP_HI = 10;
    localparam int ALUOP_LO = 9;
    localparam int SHL_BIT  = 8;
    localparam int IMM_HI   = 7;
    localparam int IMM_LO   = 0;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LDI  = 3'b001,
        OP_ALUI = 3'b010,
        OP_ST   = 3'b011,
        OP_LD   = 3'b100,
        OP_RSV5 = 3'b101,
        OP_RSV6 = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    typedef struct packed {
        logic [SEQ_IMM_W-1:0] bus_override;
        logic                 bus_override_en;
        logic                 reg_wr0;
        logic                 reg_wr1;
        logic                 reg_bus_sel;
        logic                 reg_bus_en;
        logic                 alu_b_wr;
        logic [1:0]           alu_op;
        logic                 alu_shift_left;
        logic                 alu_oe;
        logic                 ram_address_en;
        logic                 ram_write_en;
        logic                 ram_read_data_select;
        logic                 ram_oe;
    } ctrl_t;

    // Number of sources that drive the shared bus in one control word.
    function automatic logic [2:0] bus_driver_count(input ctrl_t c);
        return {2'b00, c.bus_override_en} + {2'b00, c.reg_bus_en}
             + {2'b00, c.alu_oe} + {2'b00, c.ram_oe};
    endfunction

endpackage

// File: rtl/datapath_seq_checker.sv
// datapath_seq_checker
// Simulation checker: at most one bus driver may be enabled per cycle.
// Ports:
//   clk    in  clock
//   reset  in  synchronous active-high reset (check disabled while high)
//   ctrl   in  registered control word driven to the datapath
module datapath_seq_checker
    import datapath_seq_pkg::*;
(
    input logic  clk,
    input logic  reset,
    input ctrl_t ctrl
);

    a_single_bus_driver: assert property (
        @(posedge clk) disable iff (reset) (bus_driver_count(ctrl) <= 3'd1)
    );

endmodule

// File: rtl/datapath_seq_decode.sv
// datapath_seq_decode
// Combinational decode of (opcode, step, instruction fields) into the
// datapath control word, plus "this is the last step" and "undefined opcode".
// Ports:
//   exec_en     in   decode only when the sequencer is (about to be) in EXEC
//   opcode      in   instruction opcode
//   step        in   step index within the instruction (0..2)
//   rd, ra      in   destination / address register selects
//   alu_op      in   ALU operation
//   shift_left  in   ALU shift direction
//   imm         in   immediate
//   ctrl        out  control word for this step
//   last_step   out  this step completes the instruction
//   illegal     out  opcode is undefined (101/110)
module datapath_seq_decode
    import datapath_seq_pkg::*;
(
    input  logic                 exec_en,
    input  opcode_e              opcode,
    input  logic [1:0]           step,
    input  logic                 rd,
    input  logic                 ra,
    input  logic [1:0]           alu_op,
    input  logic                 shift_left,
    input  logic [SEQ_IMM_W-1:0] imm,
    output ctrl_t                ctrl,
    output logic                 last_step,
    output logic                 illegal
);

    // Step table: each opcode's control pattern per step
    always_comb begin
        ctrl      = '0;
        last_step = 1'b0;
        illegal   = 1'b0;
        if (exec_en) begin
            case (opcode)
                OP_NOP: begin
                    last_step = 1'b1;
                end
                OP_LDI: begin
                    ctrl.bus_override    = imm;
                    ctrl.bus_override_en = 1'b1;
                    ctrl.reg_wr0         = ~rd;
                    ctrl.reg_wr1         = rd;
                    last_step            = 1'b1;
                end
                OP_ALUI: begin
                    case (step)
                        2'd0: begin
                            ctrl.bus_override    = imm;
                            ctrl.bus_override_en = 1'b1;
                            ctrl.alu_b_wr        = 1'b1;
                        end
                        2'd1: begin
                            ctrl.alu_op         = alu_op;
                            ctrl.alu_shift_left = shift_left;
                        end
                        2'd2: begin
                            ctrl.alu_op         = alu_op;
                            ctrl.alu_shift_left = shift_left;
                            ctrl.alu_oe         = 1'b1;
                            ctrl.reg_wr0        = ~rd;
                            ctrl.reg_wr1        = rd;
                            last_step           = 1'b1;
                        end
                        default: begin
                            last_step = 1'b1;
                        end
                    endcase
                end
                OP_ST, OP_LD: begin
                    if (step == 2'd0) begin
                        // Both start by latching the address held in ra
                        ctrl.reg_bus_sel    = ra;
                        ctrl.reg_bus_en     = 1'b1;
                        ctrl.ram_address_en = 1'b1;
                    end else if (opcode == OP_ST) begin
                        ctrl.reg_bus_sel  = rd;
                        ctrl.reg_bus_en   = 1'b1;
                        ctrl.ram_write_en = 1'b1;
                        last_step         = 1'b1;
                    end else begin
                        ctrl.ram_read_data_select = 1'b1;
                        ctrl.ram_oe               = 1'b1;
                        ctrl.reg_wr0              = ~rd;
                        ctrl.reg_wr1              = rd;
                        last_step                 = 1'b1;
                    end
                end
                OP_RSV5, OP_RSV6: begin
                    last_step = 1'b1;
                    illegal   = 1'b1;
                end
                OP_HALT: begin
                    last_step = 1'b1;
                end
                default: begin
                    last_step = 1'b1;
                end
            endcase
        end else begin
            last_step = 1'b0;
        end
    end

endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer
// Multi-cycle control sequencer for the 8-bit datapath. Accepts one 16-bit
// instruction per valid/ready handshake and expands it into 1-3 control steps.
// All outputs are registered: the next state/step/instruction is decoded
// ahead of the clock edge so the strobes appear in the step's own cycle.
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_instr, i_instrValid           instruction word and its valid
//   o_instrReady                    high only in IDLE
//   o_busOverride/_En               immediate onto the bus
//   o_ctrl*                         datapath control strobes
//   o_done                          pulse on the last step of an instruction
//   o_illegal                       pulse with o_done for opcodes 101/110
//   o_halted                        high in HALT until reset
//   o_retiredCount                  retired instruction count, only when
//                                   SEQ_PERF_CNT_EN is defined
module datapath_sequencer
    import datapath_seq_pkg::*;
#(
    parameter int IMM_W = SEQ_IMM_W
)
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [15:0]        i_instr,
    input  logic               i_instrValid,
    output logic               o_instrReady,
    output logic [IMM_W-1:0]   o_busOverride,
    output logic               o_busOverrideEn,
    output logic               o_ctrlRegWr0,
    output logic               o_ctrlRegWr1,
    output logic               o_ctrlRegBusSel,
    output logic               o_ctrlRegBusEn,
    output logic               o_ctrlAluBWr,
    output logic [1:0]         o_ctrlAluOp,
    output logic               o_ctrlAluShiftLeft,
    output logic               o_ctrlAluOE,
    output logic               o_ctrlRamAddressEn,
    output logic               o_ctrlRamWriteEn,
    output logic               o_ctrlRamReadDataSelect,
    output logic               o_ctrlRamOE,
    output logic               o_done,
    output logic               o_illegal,
    output logic               o_halted
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]        o_retiredCount
`endif
);

    state_e              state_r;
    state_e              state_nx_s;
    logic [1:0]          step_r;
    logic [1:0]          step_nx_s;
    logic [INSTR_W-1:0]  ir_r;
    logic [INSTR_W-1:0]  ir_nx_s;
    ctrl_t               ctrl_r;
    ctrl_t               ctrl_nx_s;
    logic                done_r;
    logic                last_nx_s;
    logic                illegal_r;
    logic                illegal_nx_s;
    logic                ready_r;
    logic                halted_r;
    logic                accept_s;

    // Ready is the registered IDLE flag, so nothing is accepted in the
    // first cycle after reset even though the state is already IDLE.
    assign accept_s = i_instrValid & ready_r;

    // Next state/step/instruction; done_r marks the current step as the last
    always_comb begin
        state_nx_s = state_r;
        step_nx_s  = step_r;
        ir_nx_s    = ir_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_EXEC;
                    step_nx_s  = 2'd0;
                    ir_nx_s    = i_instr;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (done_r) begin
                    step_nx_s = 2'd0;
                    if (opcode_e'(ir_r[OPC_HI:OPC_LO]) == OP_HALT) begin
                        state_nx_s = ST_HALT;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    step_nx_s = step_r + 2'd1;
                end
            end
            ST_HALT: begin
                state_nx_s = ST_HALT;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    datapath_seq_decode u_decode (
        .exec_en    (state_nx_s == ST_EXEC),
        .opcode     (opcode_e'(ir_nx_s[OPC_HI:OPC_LO])),
        .step       (step_nx_s),
        .rd         (ir_nx_s[RD_BIT]),
        .ra         (ir_nx_s[RA_BIT]),
        .alu_op     (ir_nx_s[ALUOP_HI:ALUOP_LO]),
        .shift_left (ir_nx_s[SHL_BIT]),
        .imm        (ir_nx_s[IMM_HI:IMM_LO]),
        .ctrl       (ctrl_nx_s),
        .last_step  (last_nx_s),
        .illegal    (illegal_nx_s)
    );

    // Sequencer state and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r   <= ST_IDLE;
            step_r    <= 2'd0;
            ir_r      <= '0;
            ctrl_r    <= '0;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
            ready_r   <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            step_r    <= step_nx_s;
            ir_r      <= ir_nx_s;
            ctrl_r    <= ctrl_nx_s;
            done_r    <= last_nx_s;
            illegal_r <= illegal_nx_s;
            ready_r   <= (state_nx_s == ST_IDLE);
            halted_r  <= (state_nx_s == ST_HALT);
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] retired_r;

    // Retired-instruction counter; wraps naturally at 16 bits
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            retired_r <= 16'h0000;
        end else if (done_r) begin
            retired_r <= retired_r + 16'h0001;
        end else begin
            retired_r <= retired_r;
        end
    end

    assign o_retiredCount = retired_r;
`endif

    datapath_seq_checker u_checker (
        .clk   (i_clk),
        .reset (i_reset),
        .ctrl  (ctrl_r)
    );

    assign o_instrReady            = ready_r;
    assign o_busOverride           = ctrl_r.bus_override;
    assign o_busOverrideEn         = ctrl_r.bus_override_en;
    assign o_ctrlRegWr0            = ctrl_r.reg_wr0;
    assign o_ctrlRegWr1            = ctrl_r.reg_wr1;
    assign o_ctrlRegBusSel         = ctrl_r.reg_bus_sel;
    assign o_ctrlRegBusEn          = ctrl_r.reg_bus_en;
    assign o_ctrlAluBWr            = ctrl_r.alu_b_wr;
    assign o_ctrlAluOp             = ctrl_r.alu_op;
    assign o_ctrlAluShiftLeft      = ctrl_r.alu_shift_left;
    assign o_ctrlAluOE             = ctrl_r.alu_oe;
    assign o_ctrlRamAddressEn      = ctrl_r.ram_address_en;
    assign o_ctrlRamWriteEn        = ctrl_r.ram_write_en;
    assign o_ctrlRamReadDataSelect = ctrl_r.ram_read_data_select;
    assign o_ctrlRamOE             = ctrl_r.ram_oe;
    assign o_done                  = done_r;
    assign o_illegal               = illegal_r;
    assign o_halted                = halted_r;

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer
// Directed and randomized stimulus for datapath_sequencer. A reference model
// expands every accepted instruction into a queue of expected per-cycle
// output words; one process compares the DUT against it on every cycle.
// Directed steps also check literal values taken from the instruction table.
// Build with SEQ_PERF_CNT_EN defined to also check o_retiredCount.
module tb_datapath_sequencer;

    typedef struct packed {
        logic [7:0] bov;
        logic       bove;
        logic       wr0;
        logic       wr1;
        logic       bsel;
        logic       ben;
        logic       bwr;
        logic [1:0] aop;
        logic       shl;
        logic       aoe;
        logic       rae;
        logic       rwe;
        logic       rds;
        logic       roe;
        logic       done;
        logic       ill;
        logic       rdy;
        logic       hlt;
    } outs_t;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [15:0] i_instr = 16'h0000;
    logic        i_instrValid = 1'b0;
    logic        o_instrReady;
    logic [7:0]  o_busOverride;
    logic        o_busOverrideEn;
    logic        o_ctrlRegWr0;
    logic        o_ctrlRegWr1;
    logic        o_ctrlRegBusSel;
    logic        o_ctrlRegBusEn;
    logic        o_ctrlAluBWr;
    logic [1:0]  o_ctrlAluOp;
    logic        o_ctrlAluShiftLeft;
    logic        o_ctrlAluOE;
    logic        o_ctrlRamAddressEn;
    logic        o_ctrlRamWriteEn;
    logic        o_ctrlRamReadDataSelect;
    logic        o_ctrlRamOE;
    logic        o_done;
    logic        o_illegal;
    logic        o_halted;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0] o_retiredCount;
`endif

    datapath_sequencer #(.IMM_W(8)) dut (
        .i_clk                   (i_clk),
        .i_reset                 (i_reset),
        .i_instr                 (i_instr),
        .i_instrValid            (i_instrValid),
        .o_instrReady            (o_instrReady),
        .o_busOverride           (o_busOverride),
        .o_busOverrideEn         (o_busOverrideEn),
        .o_ctrlRegWr0            (o_ctrlRegWr0),
        .o_ctrlRegWr1            (o_ctrlRegWr1),
        .o_ctrlRegBusSel         (o_ctrlRegBusSel),
        .o_ctrlRegBusEn          (o_ctrlRegBusEn),
        .o_ctrlAluBWr            (o_ctrlAluBWr),
        .o_ctrlAluOp             (o_ctrlAluOp),
        .o_ctrlAluShiftLeft      (o_ctrlAluShiftLeft),
        .o_ctrlAluOE             (o_ctrlAluOE),
        .o_ctrlRamAddressEn      (o_ctrlRamAddressEn),
        .o_ctrlRamWriteEn        (o_ctrlRamWriteEn),
        .o_ctrlRamReadDataSelect (o_ctrlRamReadDataSelect),
        .o_ctrlRamOE             (o_ctrlRamOE),
        .o_done                  (o_done),
        .o_illegal               (o_illegal),
        .o_halted                (o_halted)
`ifdef SEQ_PERF_CNT_EN
        ,
        .o_retiredCount          (o_retiredCount)
`endif
    );

    always #5 i_clk = ~i_clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    outs_t dut_o;
    outs_t cur_exp;
    outs_t exp_q[$];
    bit    halt_pend;
    logic [15:0] exp_cnt;

    assign dut_o = {o_busOverride, o_busOverrideEn, o_ctrlRegWr0, o_ctrlRegWr1,
                    o_ctrlRegBusSel, o_ctrlRegBusEn, o_ctrlAluBWr, o_ctrlAluOp,
                    o_ctrlAluShiftLeft, o_ctrlAluOE, o_ctrlRamAddressEn,
                    o_ctrlRamWriteEn, o_ctrlRamReadDataSelect, o_ctrlRamOE,
                    o_done, o_illegal, o_instrReady, o_halted};

    // Expand one instruction into its expected per-step output words.
    function automatic void expand(input logic [15:0] ins);
        outs_t r;
        logic rd;
        logic ra;
        rd = ins[12];
        ra = ins[11];
        r = '0;
        case (ins[15:13])
            3'b000: begin r.done = 1'b1; exp_q.push_back(r); end
            3'b001: begin
                r.bov = ins[7:0]; r.bove = 1'b1; r.wr0 = ~rd; r.wr1 = rd; r.done = 1'b1;
                exp_q.push_back(r);
            end
            3'b010: begin
                r.bov = ins[7:0]; r.bove = 1'b1; r.bwr = 1'b1;
                exp_q.push_back(r);
                r = '0; r.aop = ins[10:9]; r.shl = ins[8];
                exp_q.push_back(r);
                r.aoe = 1'b1; r.wr0 = ~rd; r.wr1 = rd; r.done = 1'b1;
                exp_q.push_back(r);
            end
            3'b011: begin
                r.bsel = ra; r.ben = 1'b1; r.rae = 1'b1;
                exp_q.push_back(r);
                r = '0; r.bsel = rd; r.ben = 1'b1; r.rwe = 1'b1; r.done = 1'b1;
                exp_q.push_back(r);
            end
            3'b100: begin
                r.bsel = ra; r.ben = 1'b1; r.rae = 1'b1;
                exp_q.push_back(r);
                r = '0; r.rds = 1'b1; r.roe = 1'b1; r.wr0 = ~rd; r.wr1 = rd; r.done = 1'b1;
                exp_q.push_back(r);
            end
            3'b111: begin r.done = 1'b1; halt_pend = 1'b1; exp_q.push_back(r); end
            default: begin r.done = 1'b1; r.ill = 1'b1; exp_q.push_back(r); end
        endcase
    endfunction

    // Model: compare this cycle, then predict the next one from live inputs.
    initial begin
        outs_t nx;
        cur_exp   = '0;
        halt_pend = 1'b0;
        exp_cnt   = 16'h0000;
        @(posedge i_clk);
        forever begin
            @(negedge i_clk);
            n_cmp++;
            if (dut_o !== cur_exp) begin
                n_bad++;
                $display("FAIL outputs t=%0t got=%h want=%h", $time, dut_o, cur_exp);
            end
`ifdef SEQ_PERF_CNT_EN
            n_cmp++;
            if (o_retiredCount !== exp_cnt) begin
                n_bad++;
                $display("FAIL retired_count t=%0t got=%0d want=%0d", $time, o_retiredCount, exp_cnt);
            end
`endif
            exp_cnt = i_reset ? 16'h0000 : (cur_exp.done ? exp_cnt + 16'h0001 : exp_cnt);
            nx = '0;
            if (i_reset) begin
                exp_q.delete();
                halt_pend = 1'b0;
            end else if (exp_q.size() > 0) begin
                nx = exp_q.pop_front();
            end else if (halt_pend) begin
                nx.hlt = 1'b1;
            end else if (cur_exp.rdy && i_instrValid) begin
                expand(i_instr);
                nx = exp_q.pop_front();
            end else begin
                nx.rdy = 1'b1;
            end
            cur_exp = nx;
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Wait (bounded) for ready, then present the instruction for one cycle.
    task automatic issue(input logic [15:0] ins);
        int k;
        k = 0;
        while (!o_instrReady && k < 30) begin
            cyc();
            k++;
        end
        if (!o_instrReady) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout instr=%h got_ready=0 want_ready=1", ins);
        end
        i_instrValid = 1'b1;
        i_instr      = ins;
        cyc();
        i_instrValid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with valid held high: nothing accepted, outputs zero
        i_reset = 1'b1; i_instrValid = 1'b1; i_instr = 16'h202A;
        repeat (10) begin
            cyc();
            chk("rst_ready", 32'(o_instrReady), 32'd0);
            chk("rst_done", 32'(o_done), 32'd0);
        end
        i_reset = 1'b0; i_instrValid = 1'b0;
        cyc();
        chk("ready_after_rst", 32'(o_instrReady), 32'd1);

        // LDI r0,0x2A
        issue(16'h202A);
        chk("ldi_bov", 32'(o_busOverride), 32'h2A);
        chk("ldi_wr0", 32'(o_ctrlRegWr0), 32'd1);
        chk("ldi_done", 32'(o_done), 32'd1);
        cyc();
        chk("ldi_ready_again", 32'(o_instrReady), 32'd1);

        // ALUI r1, op=11, shift right, imm 0x01
        issue(16'h5601);
        chk("alui_s0_bwr", 32'(o_ctrlAluBWr), 32'd1);
        chk("alui_s0_wr1", 32'(o_ctrlRegWr1), 32'd0);
        cyc();
        chk("alui_s1_op", 32'(o_ctrlAluOp), 32'd3);
        chk("alui_s1_oe", 32'(o_ctrlAluOE), 32'd0);
        cyc();
        chk("alui_s2_oe", 32'(o_ctrlAluOE), 32'd1);
        chk("alui_s2_wr1", 32'(o_ctrlRegWr1), 32'd1);
        chk("alui_s2_done", 32'(o_done), 32'd1);
        cyc();

        // ST [r0]=r1 then LD r0=[r0], valid held high throughout
        i_instrValid = 1'b1; i_instr = 16'h7000;
        cyc();
        chk("st_s0_rae", 32'(o_ctrlRamAddressEn), 32'd1);
        chk("st_s0_sel", 32'(o_ctrlRegBusSel), 32'd0);
        i_instr = 16'h8000;
        cyc();
        chk("st_s1_rwe", 32'(o_ctrlRamWriteEn), 32'd1);
        chk("st_s1_sel", 32'(o_ctrlRegBusSel), 32'd1);
        cyc();
        chk("st_ld_gap_ready", 32'(o_instrReady), 32'd1);
        cyc();
        i_instrValid = 1'b0;
        chk("ld_s0_rae", 32'(o_ctrlRamAddressEn), 32'd1);
        cyc();
        chk("ld_s1_roe", 32'(o_ctrlRamOE), 32'd1);
        chk("ld_s1_wr0", 32'(o_ctrlRegWr0), 32'd1);
        chk("ld_s1_done", 32'(o_done), 32'd1);

        // Undefined opcode then HALT
        issue(16'hA000);
        chk("ill_pulse", 32'(o_illegal), 32'd1);
        chk("ill_done", 32'(o_done), 32'd1);
        issue(16'hE000);
        chk("halt_done", 32'(o_done), 32'd1);
        i_instrValid = 1'b1; i_instr = 16'h202A;
        repeat (20) cyc();
        chk("halted", 32'(o_halted), 32'd1);
        chk("halt_ready", 32'(o_instrReady), 32'd0);
        i_instrValid = 1'b0;
        i_reset = 1'b1;
        cyc();
        chk("halt_cleared", 32'(o_halted), 32'd0);
        i_reset = 1'b0;
        cyc();
        chk("halt_rst_ready", 32'(o_instrReady), 32'd1);

        // Reset during ALUI step1 aborts with no done
        issue(16'h5601);
        cyc();
        i_reset = 1'b1;
        cyc();
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_op", 32'(o_ctrlAluOp), 32'd0);
        i_reset = 1'b0;
        cyc();
`ifdef SEQ_PERF_CNT_EN
        chk("cnt_after_abort", 32'(o_retiredCount), 32'd0);
`endif
        issue(16'h0000);
        issue(16'h0000);
        issue(16'h0000);
        cyc();
`ifdef SEQ_PERF_CNT_EN
        chk("cnt_three_nops", 32'(o_retiredCount), 32'd3);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc();
            i_reset      = ($urandom_range(0, 79) == 0) || (o_halted && $urandom_range(0, 5) == 0);
            i_instrValid = 1'($urandom_range(0, 1));
            i_instr      = 16'($urandom);
        end
        i_reset = 1'b0; i_instrValid = 1'b0;
        repeat (5) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
